// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction-memory byte port, decoder handshake and control inputs.
// The fetch unit uses the master view; the memory/decoder side uses the slave view.
interface fetch_if;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic        halt;

  modport master (
    output mem_req, mem_addr, instr, instr_valid,
    input  mem_ack, mem_rdata, instr_ready, branch_en, branch_target, halt
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_valid,
    output mem_ack, mem_rdata, instr_ready, branch_en, branch_target, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: two big-endian byte reads build a 16-bit instruction,
// which is held until the decoder takes it. Branch redirect overrides everything else.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    HOLD     = 3'd3,
    HALTED   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_pc;
  logic [7:0]  w_pc_nxt;
  logic [15:0] r_instr;
  logic [15:0] w_instr_nxt;
  logic        r_mem_req;
  logic        r_instr_valid;

  // Next-state, PC and instruction-assembly logic
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    if (bus.branch_en) begin
      // Redirect wins over ack, transfer and halt; a halted unit stays halted
      w_pc_nxt = bus.branch_target;
      if (r_state == HALTED) begin
        w_state_nxt = HALTED;
      end else begin
        w_state_nxt = FETCH_HI;
      end
    end else begin
      case (r_state)
        BOOT: begin
          if (bus.halt) begin
            w_state_nxt = HALTED;
          end else begin
            w_state_nxt = FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (bus.mem_ack) begin
            w_instr_nxt[15:8] = bus.mem_rdata;
            w_pc_nxt          = r_pc + 8'd1;
            w_state_nxt       = FETCH_LO;
          end else begin
            w_state_nxt = FETCH_HI;
          end
        end
        FETCH_LO: begin
          if (bus.mem_ack) begin
            w_instr_nxt[7:0] = bus.mem_rdata;
            w_pc_nxt         = r_pc + 8'd1;
            w_state_nxt      = HOLD;
          end else begin
            w_state_nxt = FETCH_LO;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            if (bus.halt) begin
              w_state_nxt = HALTED;
            end else begin
              w_state_nxt = FETCH_HI;
            end
          end else begin
            w_state_nxt = HOLD;
          end
        end
        HALTED: begin
          if (bus.halt) begin
            w_state_nxt = HALTED;
          end else begin
            w_state_nxt = FETCH_HI;
          end
        end
        default: begin
          w_state_nxt = BOOT;
        end
      endcase
    end
  end

  // State, PC, instruction and decoded-output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= 16'h0000;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_mem_req     <= (w_state_nxt == FETCH_HI) || (w_state_nxt == FETCH_LO);
      r_instr_valid <= (w_state_nxt == HOLD);
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;

endmodule
